// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Signed support in div_32bit is selected by DIV_SIGNED_EN.
package div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_ITER,
        DIV_FIX
    } div_state_e;

    localparam int DIV_ITERS = 32;
    localparam int DIV_CNT_W = $clog2(DIV_ITERS);
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFFFFFF;

    // Two's-complement magnitude; 32'h80000000 maps to itself as unsigned 2^31.
    function automatic logic [31:0] mag32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/CLA_32bit.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups,
// group carries chained through group generate/propagate.
module CLA_32bit (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin : lookahead
        logic       ci;
        logic [3:0] gk;
        logic [3:0] pk;
        logic [3:0] ck;
        logic       gg;
        logic       pp;
        ci  = cin;
        sum = '0;
        gk  = '0;
        pk  = '0;
        ck  = '0;
        gg  = 1'b0;
        pp  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            gk    = g[4*k +: 4];
            pk    = p[4*k +: 4];
            ck[0] = ci;
            ck[1] = gk[0] | (pk[0] & ci);
            ck[2] = gk[1] | (pk[1] & gk[0])
                  | (pk[1] & pk[0] & ci);
            ck[3] = gk[2] | (pk[2] & gk[1])
                  | (pk[2] & pk[1] & gk[0])
                  | (pk[2] & pk[1] & pk[0] & ci);
            gg    = gk[3] | (pk[3] & gk[2])
                  | (pk[3] & pk[2] & gk[1])
                  | (pk[3] & pk[2] & pk[1] & gk[0]);
            pp    = &pk;
            sum[4*k +: 4] = pk ^ ck;
            ci    = gg | (pp & ci);
        end
        cout = ci;
    end

endmodule

// File: rtl/div_step.sv
// One restoring-division step: trial subtract of the divisor from a
// 33-bit shifted remainder via CLA_32bit, keep or restore.
module div_step (
    input  logic [32:0] shifted,
    input  logic [31:0] divisor,
    output logic [31:0] rem_next,
    output logic        qbit
);

    logic [31:0] diff;
    logic        cout;

    CLA_32bit u_cla (
        .a    (shifted[31:0]),
        .b    (~divisor),
        .cin  (1'b1),
        .sum  (diff),
        .cout (cout)
    );

    // Bit 32 of the shifted value alone guarantees shifted >= divisor;
    // otherwise the adder carry-out is the no-borrow indication.
    assign qbit     = shifted[32] | cout;
    assign rem_next = qbit ? diff : shifted[31:0];

endmodule

// File: rtl/div_32bit.sv
// Sequential 32-bit restoring divider, one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement signed division.
module div_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e           state;
    logic [DIV_CNT_W-1:0] count;
    logic [31:0]          prem;
    logic [31:0]          qsh;
    logic [31:0]          dvs;
    logic [31:0]          dvd_raw;
    logic [31:0]          rem_next;
    logic                 dz;
    logic                 qbit;
`ifdef DIV_SIGNED_EN
    logic                 neg_q;
    logic                 neg_r;
`endif

    // qsh shifts dividend bits out at the top and quotient bits in below.
    div_step u_step (
        .shifted  ({prem, qsh[31]}),
        .divisor  (dvs),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= DIV_IDLE;
            count       <= '0;
            prem        <= '0;
            qsh         <= '0;
            dvs         <= '0;
            dvd_raw     <= '0;
            dz          <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            unique case (state)
                DIV_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= DIV_ITER;
                        busy    <= 1'b1;
                        count   <= '0;
                        prem    <= '0;
                        dvd_raw <= dividend;
                        dz      <= (divisor == '0);
`ifdef DIV_SIGNED_EN
                        qsh     <= mag32(dividend);
                        dvs     <= mag32(divisor);
                        neg_q   <= dividend[31] ^ divisor[31];
                        neg_r   <= dividend[31];
`else
                        qsh     <= dividend;
                        dvs     <= divisor;
`endif
                    end
                end
                DIV_ITER: begin
                    prem  <= rem_next;
                    qsh   <= {qsh[30:0], qbit};
                    count <= count + 1'b1;
                    if (count == DIV_CNT_W'(DIV_ITERS - 1))
                        state <= DIV_FIX;
                end
                DIV_FIX: begin
                    if (dz) begin
                        quotient  <= DIV_BY_ZERO_Q;
                        remainder <= dvd_raw;
                    end else begin
`ifdef DIV_SIGNED_EN
                        quotient  <= neg_q ? -qsh : qsh;
                        remainder <= neg_r ? -prem : prem;
`else
                        quotient  <= qsh;
                        remainder <= prem;
`endif
                    end
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= DIV_IDLE;
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_32bit.sv
// Self-checking bench for div_32bit: directed cases plus random
// operands checked against a plain-arithmetic reference.
module tb_div_32bit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int tests;
    int fails;

    div_32bit #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz);
        int sa;
        int sb;
        sa = a;
        sb = b;
        dz = (b == 0);
        if (b == 0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else begin
`ifdef DIV_SIGNED_EN
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                q = 32'h80000000;
                r = 0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
`else
            q = a / b;
            r = a % b;
`endif
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic [31:0] a, input logic [31:0] b);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int rp,
                             input logic [31:0] eq, input logic [31:0] er,
                             input logic edz);
        int k;
        k = 0;
        check({tag, "_done_low"}, {31'b0, done}, 32'd0);
        while (done !== 1'b1 && k < 40) begin
            check({tag, "_busy"}, {31'b0, busy}, 32'd1);
            if (k == rp) begin
                start    = 1'b1;
                dividend = 32'hDEADBEEF;
                divisor  = 32'd3;
            end
            if (k == rp + 1)
                start = 1'b0;
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, k, 32'd33);
        check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
    endtask

    task automatic run_model(input string tag, input logic [31:0] a,
                             input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        ref_div(a, b, q, r, dz);
        @(negedge clk);
        launch(a, b);
        wait_done(tag, -5, q, r, dz);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        tests    = 0;
        fails    = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", {31'b0, div_by_zero}, 32'd0);
        reset_n = 1'b1;

        // Basic divide with a start re-pulse at edge 10
        @(negedge clk);
        launch(32'd100, 32'd7);
        wait_done("basic", 9, 32'd14, 32'd2, 1'b0);
        // Start during the done cycle
        launch(32'd9, 32'd3);
        wait_done("b2b", -5, 32'd3, 32'd0, 1'b0);

        @(negedge clk);
        check("done_pulse", {31'b0, done}, 32'd0);

        @(negedge clk);
        launch(32'hFFFFFF9C, 32'd7);
`ifdef DIV_SIGNED_EN
        wait_done("neg", -5, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
`else
        wait_done("neg", -5, 32'h24924916, 32'd2, 1'b0);
`endif
        @(negedge clk);
        launch(32'h12345678, 32'd0);
        wait_done("dbz", -5, 32'hFFFFFFFF, 32'h12345678, 1'b1);

        run_model("ovf", 32'h80000000, 32'hFFFFFFFF);
`ifdef DIV_SIGNED_EN
        check("ovf_q_const", quotient, 32'h80000000);
        check("ovf_r_const", remainder, 32'd0);
`endif

        // Reset abort at cycle 12 of a divide
        @(negedge clk);
        launch(32'd1000, 32'd3);
        repeat (11) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        check("abort_dz", {31'b0, div_by_zero}, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("abort_nodone", {31'b0, done}, 32'd0);
        end
        reset_n = 1'b1;
        repeat (30) begin
            @(negedge clk);
            check("abort_idle", {31'b0, done}, 32'd0);
        end
        run_model("after_abort", 32'd50, 32'd5);
        check("after_abort_q10", quotient, 32'd10);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            unique case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 15);
                2: rb = (i % 8 == 2) ? 32'd0 : 32'($urandom_range(1, 65535));
                default: rb = -32'($urandom_range(1, 1000));
            endcase
            run_model("rand", ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
